// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline sequencing controller:
// control-vector layout, opcodes, FSM states and sequencing-control encodings.
package hazard_stall_ctrl_pkg;

  // Control vector carried in ID/EX:
  // {regdst[1:0], jump, branch, memread, memtoreg[1:0], aluop[1:0], memwrite, alusrc, regwrite}
  localparam int CTRL_W         = 12;
  localparam int CTRL_REGDST_HI = 11;
  localparam int CTRL_REGDST_LO = 10;
  localparam int CTRL_JUMP      = 9;
  localparam int CTRL_BRANCH    = 8;
  localparam int CTRL_MEMREAD   = 7;
  localparam int CTRL_MEMTOREG_HI = 6;
  localparam int CTRL_MEMTOREG_LO = 5;
  localparam int CTRL_ALUOP_HI  = 4;
  localparam int CTRL_ALUOP_LO  = 3;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_ALUSRC    = 1;
  localparam int CTRL_REGWRITE  = 0;

  // A bubble is simply an all-zero control vector: no writes, no memory access.
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  // Primary opcodes understood by the core.
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  // Sequencing FSM states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  // Bundle of the six pipeline sequencing controls.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_hold;
    logic memwb_bubble;
  } seq_ctrl_t;

  // Canonical control patterns, ordered {pc_write, ifid_write, ifid_flush,
  // idex_bubble, exmem_hold, memwb_bubble}.
  localparam seq_ctrl_t SEQ_RESET    = seq_ctrl_t'(6'b001101);
  localparam seq_ctrl_t SEQ_NORMAL   = seq_ctrl_t'(6'b110000);
  localparam seq_ctrl_t SEQ_FREEZE   = seq_ctrl_t'(6'b000011);
  localparam seq_ctrl_t SEQ_BRANCH   = seq_ctrl_t'(6'b101100);
  localparam seq_ctrl_t SEQ_LOADUSE  = seq_ctrl_t'(6'b000100);
  localparam seq_ctrl_t SEQ_JUMP     = seq_ctrl_t'(6'b111000);

  // True for opcodes that touch data memory in the MEM stage.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load currently in EX will write.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       loaduse_o
);

  logic rsMatch;
  logic rtMatch;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  always_comb begin
    rsMatch   = (ex_rt_i == id_rs_i);
    rtMatch   = id_uses_rt_i & (ex_rt_i == id_rt_i);
    loaduse_o = ex_memread_i & (ex_rt_i != 5'd0) & (rsMatch | rtMatch);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core. Chooses each
// cycle whether PC and pipeline registers advance, hold, flush or bubble,
// counts stall cycles and latches a sticky memory-timeout error.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             jump_id,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err
);

  localparam int                WCNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              mem_err_q, mem_err_d;

  logic              loaduse;
  logic              memstall;
  seq_ctrl_t         ctrl;

  hazard_detect u_hazard_detect (
    .ex_memread_i (ex_memread),
    .ex_rt_i      (ex_rt),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .loaduse_o    (loaduse)
  );

  assign memstall = dmem_req & ~dmem_ready;

  // State, wait counter, stall counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wcnt_q        <= '0;
      stall_count_q <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      stall_count_q <= stall_count_d;
      mem_err_q     <= mem_err_d;
    end
  end

  // Next state: track consecutive memory wait cycles and trip to ERROR on timeout.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      ST_RUN: begin
        if (memstall) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = WCNT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (memstall) begin
          wcnt_d = wcnt_q + WCNT_ONE;
          if (wcnt_d == WCNT_LIMIT) begin
            state_d   = ST_ERROR;
            mem_err_d = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end
      end
      ST_ERROR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Outputs: reset pattern while reset is held, full freeze in ERROR,
  // otherwise the hazard priority memstall > branch > load-use > jump.
  always_comb begin
    ctrl = SEQ_NORMAL;
    if (rst) begin
      ctrl = SEQ_RESET;
    end else if (state_q == ST_ERROR) begin
      ctrl = SEQ_FREEZE;
    end else if (memstall) begin
      ctrl = SEQ_FREEZE;
    end else if (branch_taken) begin
      ctrl = SEQ_BRANCH;
    end else if (loaduse) begin
      ctrl = SEQ_LOADUSE;
    end else if (jump_id) begin
      ctrl = SEQ_JUMP;
    end
  end

  // Stall counter counts every cycle the PC is held, sticking at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!ctrl.pc_write && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_hold   = ctrl.exmem_hold;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign stall_count  = stall_count_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl with a short timeout and a narrow
// stall counter so timeout and saturation are reachable quickly.
module tb_hazard_stall_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;
  localparam int CNT_SAT    = 15;

  // Expected patterns {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble}
  localparam logic [5:0] EXP_RESET   = 6'b001101;
  localparam logic [5:0] EXP_NORMAL  = 6'b110000;
  localparam logic [5:0] EXP_FREEZE  = 6'b000011;
  localparam logic [5:0] EXP_LOADUSE = 6'b000100;
  localparam logic [5:0] EXP_JUMP    = 6'b111000;
  localparam logic [5:0] EXP_BRANCH  = 6'b101100;
  localparam logic [5:0] MASK_BRANCH = 6'b101111;

  logic                clk;
  logic                rst;
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                id_uses_rt;
  logic                jump_id;
  logic                ex_memread;
  logic [4:0]          ex_rt;
  logic                branch_taken;
  logic                dmem_req;
  logic                dmem_ready;
  logic                pc_write;
  logic                ifid_write;
  logic                ifid_flush;
  logic                idex_bubble;
  logic                exmem_hold;
  logic                memwb_bubble;
  logic [TB_CNT_W-1:0] stall_count;
  logic                mem_err;
  logic [5:0]          ctrlVec;

  int errors;
  int checks;
  int expStall;

  hazard_stall_ctrl #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .jump_id      (jump_id),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_hold   (exmem_hold),
    .memwb_bubble (memwb_bubble),
    .stall_count  (stall_count),
    .mem_err      (mem_err)
  );

  assign ctrlVec = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble};

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive all hazard inputs at once.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                               input logic jmp, input logic memrd, input logic [4:0] exRt,
                               input logic br, input logic req, input logic rdy);
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = usesRt;
    jump_id      = jmp;
    ex_memread   = memrd;
    ex_rt        = exRt;
    branch_taken = br;
    dmem_req     = req;
    dmem_ready   = rdy;
    #1;
  endtask

  // Advance one clock edge; the expected stall count follows the expected pc_write.
  task automatic tick(input logic expPcw);
    @(posedge clk);
    if (!rst && !expPcw && expStall != CNT_SAT) expStall++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctrlVec !== EXP_RESET) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrlVec, EXP_RESET);
    end
    checks++;
    if (stall_count !== 4'd0 || mem_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got count=%0d err=%b expected count=0 err=0", stall_count, mem_err);
    end
    @(negedge clk);
    rst = 1'b0;
    expStall = 0;
    #1;
    checks++;
    if (ctrlVec !== EXP_NORMAL) begin
      errors++;
      $display("[TB] FAIL post_reset_ctrl: got %b expected %b", ctrlVec, EXP_NORMAL);
    end
    tick(1'b1);
    checks++;
    if (stall_count !== 4'(expStall)) begin
      errors++;
      $display("[TB] FAIL post_reset_count: got %0d expected %0d", stall_count, expStall);
    end
  endtask

  task automatic test_load_use();
    // lw $8 in EX, add reading $8 in ID
    applyStimulus(5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrlVec !== EXP_LOADUSE) begin
      errors++;
      $display("[TB] FAIL loaduse_rs: got %b expected %b", ctrlVec, EXP_LOADUSE);
    end
    tick(1'b0);
    // Bubble now in EX, load in MEM completing at once
    applyStimulus(5'd8, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctrlVec !== EXP_NORMAL) begin
      errors++;
      $display("[TB] FAIL loaduse_release: got %b expected %b", ctrlVec, EXP_NORMAL);
    end
    tick(1'b1);
    // Load into $0 never stalls
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrlVec !== EXP_NORMAL) begin
      errors++;
      $display("[TB] FAIL loaduse_r0: got %b expected %b", ctrlVec, EXP_NORMAL);
    end
    tick(1'b1);
    // rt dependency counts only when the ID instruction reads rt
    applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrlVec !== EXP_LOADUSE) begin
      errors++;
      $display("[TB] FAIL loaduse_rt: got %b expected %b", ctrlVec, EXP_LOADUSE);
    end
    tick(1'b0);
    applyStimulus(5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrlVec !== EXP_NORMAL) begin
      errors++;
      $display("[TB] FAIL loaduse_rt_unused: got %b expected %b", ctrlVec, EXP_NORMAL);
    end
    tick(1'b1);
    checks++;
    if (stall_count !== 4'(expStall)) begin
      errors++;
      $display("[TB] FAIL loaduse_count: got %0d expected %0d", stall_count, expStall);
    end
  endtask

  task automatic test_branch();
    // Taken branch together with a load-use hazard: the branch wins
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    checks++;
    if ((ctrlVec & MASK_BRANCH) !== EXP_BRANCH) begin
      errors++;
      $display("[TB] FAIL branch_over_loaduse: got %b expected %b (ifid_write ignored)", ctrlVec, EXP_BRANCH);
    end
    tick(1'b1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall_count !== 4'(expStall)) begin
      errors++;
      $display("[TB] FAIL branch_count: got %0d expected %0d", stall_count, expStall);
    end
  endtask

  task automatic test_jump();
    applyStimulus(5'd4, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrlVec !== EXP_JUMP) begin
      errors++;
      $display("[TB] FAIL jump: got %b expected %b", ctrlVec, EXP_JUMP);
    end
    tick(1'b1);
    // Load-use outranks a jump
    applyStimulus(5'd4, 5'd5, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrlVec !== EXP_LOADUSE) begin
      errors++;
      $display("[TB] FAIL loaduse_over_jump: got %b expected %b", ctrlVec, EXP_LOADUSE);
    end
    tick(1'b0);
  endtask

  task automatic test_mem_wait();
    int base;
    base = expStall;
    // Branch and load-use present while memory stalls: memstall wins
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      checks++;
      if (ctrlVec !== EXP_FREEZE) begin
        errors++;
        $display("[TB] FAIL memwait_freeze%0d: got %b expected %b", i, ctrlVec, EXP_FREEZE);
      end
      tick(1'b0);
    end
    // Ready cycle: priority resumes immediately, branch taken
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1);
    checks++;
    if ((ctrlVec & MASK_BRANCH) !== EXP_BRANCH) begin
      errors++;
      $display("[TB] FAIL memwait_ready: got %b expected %b", ctrlVec, EXP_BRANCH);
    end
    tick(1'b1);
    checks++;
    if (stall_count !== 4'(base + 3) || mem_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL memwait_count: got count=%0d err=%b expected count=%0d err=0", stall_count, mem_err, base + 3);
    end
    // Request withdrawn mid-wait returns to RUN and restarts the timeout
    for (int i = 0; i < 2; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick(1'b0);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrlVec !== EXP_NORMAL) begin
      errors++;
      $display("[TB] FAIL memwait_drop: got %b expected %b", ctrlVec, EXP_NORMAL);
    end
    tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick(1'b0);
    end
    checks++;
    if (mem_err !== 1'b0 || ctrlVec !== EXP_FREEZE) begin
      errors++;
      $display("[TB] FAIL memwait_restart: got err=%b ctrl=%b expected err=0 ctrl=%b", mem_err, ctrlVec, EXP_FREEZE);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    tick(1'b1);
    checks++;
    if (stall_count !== 4'(expStall)) begin
      errors++;
      $display("[TB] FAIL memwait_total: got %0d expected %0d", stall_count, expStall);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    expStall = 0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0);
      checks++;
      if (mem_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_early%0d: got %b expected 0", i, mem_err);
      end
    end
    tick(1'b0);
    checks++;
    if (mem_err !== 1'b1 || ctrlVec !== EXP_FREEZE) begin
      errors++;
      $display("[TB] FAIL timeout_trip: got err=%b ctrl=%b expected err=1 ctrl=%b", mem_err, ctrlVec, EXP_FREEZE);
    end
    // ERROR ignores everything, even a ready memory and a jump
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0);
    tick(1'b0);
    checks++;
    if (mem_err !== 1'b1 || ctrlVec !== EXP_FREEZE || stall_count !== 4'(expStall)) begin
      errors++;
      $display("[TB] FAIL error_hold: got err=%b ctrl=%b count=%0d expected err=1 ctrl=%b count=%0d",
               mem_err, ctrlVec, stall_count, EXP_FREEZE, expStall);
    end
    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ctrlVec !== EXP_RESET || mem_err !== 1'b0 || stall_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got ctrl=%b err=%b count=%0d expected ctrl=%b err=0 count=0",
               ctrlVec, mem_err, stall_count, EXP_RESET);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    expStall = 0;
    #1;
    checks++;
    if (ctrlVec !== EXP_NORMAL) begin
      errors++;
      $display("[TB] FAIL after_error_reset: got %b expected %b", ctrlVec, EXP_NORMAL);
    end
  endtask

  task automatic test_saturation();
    applyStimulus(5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0);
    checks++;
    if (stall_count !== 4'(expStall)) begin
      errors++;
      $display("[TB] FAIL sat_mid: got %0d expected %0d", stall_count, expStall);
    end
    for (int i = 0; i < 10; i++) tick(1'b0);
    checks++;
    if (stall_count !== 4'(expStall) || expStall != CNT_SAT) begin
      errors++;
      $display("[TB] FAIL sat_hold: got %0d expected %0d", stall_count, CNT_SAT);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    errors   = 0;
    checks   = 0;
    expStall = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
